// File: rtl/ps_stk_pkg.sv
// Shared constants and helper types for the PS PC/status stack.
package ps_stk_pkg;

  localparam logic [4:0] PS_PCSTK_ADD = 5'b00100;
  localparam int PS_STK_DW    = 16;
  localparam int PS_STK_DEPTH = 8;

  // Stack operation resolved for the current cycle.
  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_PUSH_POP,
    OP_OVR,
    OP_OVR_POP,
    OP_POP
  } stk_op_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ps_stk_mem.sv
// DEPTH x DW register array: one synchronous write port, one combinational read port.
module ps_stk_mem #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DW-1:0]            wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DW-1:0]            rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Synchronous write, no reset on the storage.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ps_pc_stack.sv
// PCSTK register of the PS register space: LIFO with sticky overflow/underflow flags.
module ps_pc_stack
  import ps_stk_pkg::*;
#(
  parameter int DW    = PS_STK_DW,
  parameter int DEPTH = PS_STK_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps_pshstck,
  input  logic                          ps_popstck,
  input  logic                          ps_wrt_en,
  input  logic [4:0]                    ps_wrt_add,
  input  logic [4:0]                    ps_rd_add,
  input  logic [DW-1:0]                 ps_wrt_data,
  input  logic                          ps_stk_clr,
  output logic [DW-1:0]                 ps_stk_dout,
  output logic [cnt_width(DEPTH)-1:0]   ps_stk_cnt,
  output logic                          ps_stk_empty,
  output logic                          ps_stk_full,
  output logic                          ps_stk_ovf,
  output logic                          ps_stk_udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [CW-1:0] cnt, cnt_nxt;
  logic          psh_pnd;
  logic          stk_wr, rd_hit, pop, empty, full;
  logic          ovf_set, udf_set;
  logic          mem_we;
  logic [AW-1:0] mem_wa, top_idx;
  logic [DW-1:0] top_data;
  stk_op_e       op;

  assign stk_wr  = ps_wrt_en & (ps_wrt_add == PS_PCSTK_ADD);
  assign rd_hit  = (ps_rd_add == PS_PCSTK_ADD);
  assign pop     = ps_popstck & rd_hit;
  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign top_idx = AW'(cnt - CW'(1));

  ps_stk_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (mem_wa),
    .wr_data (ps_wrt_data),
    .rd_addr (top_idx),
    .rd_data (top_data)
  );

  // Resolve push / overwrite / pop for this cycle and derive the array write and counter update.
  // A write landing in the same cycle as a pop is consumed through the bypass, never stored.
  always_comb begin
    op      = OP_NONE;
    mem_we  = 1'b0;
    mem_wa  = top_idx;
    cnt_nxt = cnt;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (stk_wr && psh_pnd) op = pop ? OP_PUSH_POP : OP_PUSH;
    else if (stk_wr)       op = pop ? OP_OVR_POP  : OP_OVR;
    else if (pop)          op = OP_POP;
    case (op)
      OP_PUSH: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          mem_we  = 1'b1;
          mem_wa  = cnt[AW-1:0];
          cnt_nxt = cnt + CW'(1);
        end
      end
      OP_OVR: begin
        mem_we = 1'b1;
        mem_wa = empty ? '0 : top_idx;
      end
      OP_OVR_POP, OP_POP: begin
        if (empty) udf_set = 1'b1;
        else       cnt_nxt = cnt - CW'(1);
      end
      default: ;
    endcase
  end

  // Occupancy, pending push and sticky flags; a set event beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      psh_pnd    <= 1'b0;
      ps_stk_ovf <= 1'b0;
      ps_stk_udf <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      psh_pnd    <= ps_pshstck;
      ps_stk_ovf <= ovf_set | (ps_stk_ovf & ~ps_stk_clr);
      ps_stk_udf <= udf_set | (ps_stk_udf & ~ps_stk_clr);
    end
  end

  // Read data: same-cycle write bypass, else top of stack, zero when empty.
  always_comb begin
    ps_stk_dout = '0;
    if (stk_wr && rd_hit) ps_stk_dout = ps_wrt_data;
    else if (!empty)      ps_stk_dout = top_data;
  end

  assign ps_stk_cnt   = cnt;
  assign ps_stk_empty = empty;
  assign ps_stk_full  = full;

endmodule

// File: tb/tb_ps_pc_stack.sv
// Self-checking bench for ps_pc_stack with a LIFO scoreboard of expected pop data.
module tb_ps_pc_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps_pshstck, ps_popstck, ps_wrt_en, ps_stk_clr;
  logic [4:0]  ps_wrt_add, ps_rd_add;
  logic [15:0] ps_wrt_data;
  logic [15:0] ps_stk_dout;
  logic [3:0]  ps_stk_cnt;
  logic        ps_stk_empty, ps_stk_full, ps_stk_ovf, ps_stk_udf;

  logic [15:0] model [$];
  int errors = 0;
  int checks = 0;

  ps_pc_stack #(.DW(16), .DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ps_pshstck   (ps_pshstck),
    .ps_popstck   (ps_popstck),
    .ps_wrt_en    (ps_wrt_en),
    .ps_wrt_add   (ps_wrt_add),
    .ps_rd_add    (ps_rd_add),
    .ps_wrt_data  (ps_wrt_data),
    .ps_stk_clr   (ps_stk_clr),
    .ps_stk_dout  (ps_stk_dout),
    .ps_stk_cnt   (ps_stk_cnt),
    .ps_stk_empty (ps_stk_empty),
    .ps_stk_full  (ps_stk_full),
    .ps_stk_ovf   (ps_stk_ovf),
    .ps_stk_udf   (ps_stk_udf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ps_pshstck  = 1'b0;
    ps_popstck  = 1'b0;
    ps_wrt_en   = 1'b0;
    ps_wrt_add  = 5'd0;
    ps_rd_add   = 5'd0;
    ps_wrt_data = 16'h0000;
    ps_stk_clr  = 1'b0;
  endtask

  task automatic do_push(input logic [15:0] d);
    ps_pshstck = 1'b1;
    cyc();
    ps_pshstck  = 1'b0;
    ps_wrt_en   = 1'b1;
    ps_wrt_add  = 5'd4;
    ps_wrt_data = d;
    if (model.size() < 8) model.push_back(d);
    cyc();
    idle();
  endtask

  task automatic do_pop();
    logic [15:0] exp;
    ps_popstck = 1'b1;
    ps_rd_add  = 5'd4;
    #1;
    exp = (model.size() > 0) ? model.pop_back() : 16'h0000;
    checks++;
    if (ps_stk_dout !== exp) begin
      errors++;
      $display("FAIL pop_dout: got %h expected %h", ps_stk_dout, exp);
    end
    cyc();
    idle();
  endtask

  task automatic check_top(input string name, input logic [15:0] exp);
    ps_rd_add = 5'd4;
    #1;
    checks++;
    if (ps_stk_dout !== exp) begin
      errors++;
      $display("FAIL %s: dout got %h expected %h", name, ps_stk_dout, exp);
    end
    ps_rd_add = 5'd0;
  endtask

  task automatic check_status(input string name, input logic [3:0] cnt,
                              input logic empty, input logic full,
                              input logic ovf, input logic udf);
    checks++;
    if ({ps_stk_cnt, ps_stk_empty, ps_stk_full, ps_stk_ovf, ps_stk_udf} !==
        {cnt, empty, full, ovf, udf}) begin
      errors++;
      $display("FAIL %s: cnt/empty/full/ovf/udf got %0d/%b/%b/%b/%b expected %0d/%b/%b/%b/%b",
               name, ps_stk_cnt, ps_stk_empty, ps_stk_full, ps_stk_ovf, ps_stk_udf,
               cnt, empty, full, ovf, udf);
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    check_status("reset_status", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_top("reset_dout", 16'h0000);
  endtask

  task automatic test_lifo();
    do_push(16'h1111);
    do_push(16'h2222);
    do_push(16'h3333);
    check_status("lifo_after_push", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    check_top("lifo_top", 16'h3333);
    for (int i = 0; i < 3; i++) do_pop();
    check_status("lifo_after_pop", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) do_push(16'h0100 + 16'(i));
    check_status("ovf_full", 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    do_push(16'hDEAD);
    check_status("ovf_set", 4'd8, 1'b0, 1'b1, 1'b1, 1'b0);
    check_top("ovf_top_kept", 16'h0108);
    ps_stk_clr = 1'b1;
    cyc();
    ps_stk_clr = 1'b0;
    check_status("ovf_clr", 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) do_pop();
    check_status("ovf_drained", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_underflow();
    do_pop();
    check_status("udf_set", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    ps_stk_clr = 1'b1;
    cyc();
    ps_stk_clr = 1'b0;
    check_status("udf_clr", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_push(16'h1234);
    ps_pshstck = 1'b1;
    cyc();
    ps_pshstck  = 1'b0;
    ps_wrt_en   = 1'b1;
    ps_wrt_add  = 5'd4;
    ps_wrt_data = 16'hAAAA;
    ps_popstck  = 1'b1;
    ps_rd_add   = 5'd4;
    #1;
    checks++;
    if (ps_stk_dout !== 16'hAAAA) begin
      errors++;
      $display("FAIL push_pop_bypass: got %h expected %h", ps_stk_dout, 16'hAAAA);
    end
    cyc();
    idle();
    check_status("push_pop_status", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_top("push_pop_top", 16'h1234);
    do_pop();
  endtask

  task automatic test_direct_write();
    do_push(16'h5555);
    ps_wrt_en   = 1'b1;
    ps_wrt_add  = 5'd4;
    ps_wrt_data = 16'h7777;
    ps_rd_add   = 5'd4;
    #1;
    checks++;
    if (ps_stk_dout !== 16'h7777) begin
      errors++;
      $display("FAIL direct_bypass: got %h expected %h", ps_stk_dout, 16'h7777);
    end
    void'(model.pop_back());
    model.push_back(16'h7777);
    cyc();
    idle();
    check_status("direct_status", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_top("direct_top", 16'h7777);
    do_pop();
  endtask

  task automatic test_reset_mid_push();
    ps_pshstck = 1'b1;
    cyc();
    ps_pshstck  = 1'b0;
    rst         = 1'b1;
    ps_wrt_en   = 1'b1;
    ps_wrt_add  = 5'd4;
    ps_wrt_data = 16'h8888;
    cyc();
    rst         = 1'b0;
    ps_wrt_data = 16'h9999;
    cyc();
    idle();
    check_status("rst_mid_push", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_top("rst_mid_push_dout", 16'h0000);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_direct_write();
    test_reset_mid_push();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps_pc_stack.md
# ps_pc_stack

Hardware PC/status stack sitting directly downstream of the PS universal-register address decoder. It consumes the decoder's registered write port (`ps_wrt_en`/`ps_wrt_add`) and its combinational read address (`ps_rd_add`), together with the raw `ps_pshstck`/`ps_popstck` strobes. It implements register 5'b00100 of the PS register space (PCSTK) as a LIFO with overflow and underflow detection. Push data lands one cycle after the push instruction is decoded, matching the decoder's registered write path; pop data is returned combinationally in the pop's decode cycle.

## Interface
- `DW`, 16, stack entry / data bus width
- `DEPTH`, 8, number of stack entries (power of 2, ≥2)
- `clk`  in  1  single clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `ps_pshstck`  in  1  push instruction in decode (same cycle as decoder input)
- `ps_popstck`  in  1  pop instruction in decode
- `ps_wrt_en`  in  1  registered PS-register write enable from decoder
- `ps_wrt_add`  in  5  registered PS-register write address
- `ps_rd_add`  in  5  combinational PS-register read address
- `ps_wrt_data`  in  DW  write data accompanying `ps_wrt_en`
- `ps_stk_clr`  in  1  clear sticky overflow/underflow flags
- `ps_stk_dout`  out  DW  PCSTK read data (top of stack, with bypass)
- `ps_stk_cnt`  out  $clog2(DEPTH)+1  current occupancy
- `ps_stk_empty`  out  1  `ps_stk_cnt == 0`
- `ps_stk_full`  out  1  `ps_stk_cnt == DEPTH`
- `ps_stk_ovf`  out  1  sticky: push attempted while full
- `ps_stk_udf`  out  1  sticky: pop attempted while empty

## Operation
- Push pending flag `psh_pnd` <= `ps_pshstck` each cycle. Holds for exactly one cycle.
- Stack write qualifier: `stk_wr = ps_wrt_en & (ps_wrt_add == 5'b00100)`.
- `stk_wr & psh_pnd` is a push:
  - If not full: write `ps_wrt_data` to entry `cnt`; `cnt` +1.
  - If full: data dropped, `cnt` unchanged, `ps_stk_ovf` set.
- `stk_wr & !psh_pnd` is a direct ureg write to PCSTK:
  - Overwrites the top entry (`cnt-1`); `cnt` unchanged.
  - If empty: writes entry 0 with `cnt` left at 0, so the value is not visible.
- Pop is `ps_popstck & (ps_rd_add == 5'b00100)`:
  - `ps_stk_dout` = top entry; `cnt` -1 at the edge.
  - If empty: `ps_stk_dout` = 0, `cnt` stays 0, `ps_stk_udf` set.
- Plain read of address 4 without `ps_popstck` returns the top entry and leaves `cnt` unchanged. Empty returns 0.
- Bypass: if `stk_wr` and a read of address 4 occur in the same cycle, `ps_stk_dout` = `ps_wrt_data`.
- Push write and pop in the same cycle (push N immediately followed by pop N+1):
  - Dout = `ps_wrt_data` (bypass); `cnt` unchanged; no array write.
  - No ovf/udf, even if full or empty.
- Direct write and pop in the same cycle: dout = `ps_wrt_data`, `cnt` -1, no array write.
- `ps_pshstck` and `ps_popstck` both high: `psh_pnd` is still captured, and the pop is processed normally. The decoder never generates this.
- `ps_stk_clr` clears both sticky flags. A set event in the same cycle wins.
- Reset clears `cnt`, `psh_pnd`, `ps_stk_ovf` and `ps_stk_udf`; array contents are don't-care.
- Reset values: `ps_stk_dout` = 0 (empty), `ps_stk_cnt` = 0, `ps_stk_empty` = 1, `ps_stk_full` = 0, `ps_stk_ovf` = 0, `ps_stk_udf` = 0.
- Reset asserted mid-push (while `psh_pnd` = 1) cancels the push. A `stk_wr` in the cycle after reset is treated as a direct write.

## Timing
- Push: `ps_pshstck` in cycle c; data written at the end of cycle c+1; visible on `ps_stk_dout` from cycle c+2 (cycle c+1 via bypass).
- Pop: dout is combinational in cycle c; `cnt` update visible in cycle c+1.
- `ps_stk_empty`, `ps_stk_full` and `ps_stk_cnt` are combinational from the `cnt` register, so they change one cycle after the causing event.
- Sticky flags are registered and rise one cycle after the offending event.
- No stall or back-pressure: every request completes in one cycle.

## Structure
- Package `ps_stk_pkg` holds:
  - `PS_PCSTK_ADD` = 5'b00100
  - default `DW` and `DEPTH`
  - a function computing the count width
- Sub-module `ps_stk_mem`: DEPTH×DW register array with one synchronous write port and one combinational read port, no reset.
- Top level owns: `cnt`, `psh_pnd`, sticky flags, bypass mux, push/pop/overwrite arbitration.

## Test plan
- Reset, then 3 pushes of 0x1111/0x2222/0x3333, each as `ps_pshstck` then `stk_wr` next cycle → `cnt` = 3, dout = 0x3333; 3 pops return 0x3333, 0x2222, 0x1111; `empty` = 1.
- 9 pushes with DEPTH = 8 → `full` = 1 after the 8th push; the 9th sets `ovf`; top still holds the 8th value; `ps_stk_clr` → `ovf` = 0.
- Pop on empty → dout = 0, `cnt` = 0, `udf` = 1 one cycle later.
- Push 0xAAAA immediately followed by a pop in the write cycle → dout = 0xAAAA, `cnt` unchanged, array top unchanged.
- Stack holds 0x5555, direct write 0x7777 with no pending push → `cnt` stays 1, next read of address 4 returns 0x7777.
- `rst` asserted in the cycle after `ps_pshstck` → push cancelled: `cnt` = 0, all flags 0.
